// File: rtl/cvw.sv
// Shared package for the MAC sequencer.
// Holds the sequencer state enum and the funct3 op encodings.
package cvw;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mac_state_t;

  localparam logic [2:0] MAC_OP_MAC = 3'b000;
  localparam logic [2:0] MAC_OP_CLR = 3'b001;
  localparam logic [2:0] MAC_OP_RD  = 3'b010;

endpackage

// File: rtl/mac_acc.sv
// mac_acc: accumulator register plus its update adder.
// Build option: MAC_SATURATE_EN -> signed saturating add; otherwise wrap.
// Ports:
//   clk, reset  clock, synchronous active-high reset (acc -> 0)
//   clr_i       clear acc on the next edge
//   we_i        load acc with sum_o on the next edge
//   addend_i    value added to acc
//   acc_o       current acc
//   sum_o       acc + addend_i (wrapped or saturated)
module mac_acc import cvw::*; #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] addend_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] sum_o
);

  logic [XLEN-1:0] acc_q, acc_d, sum_raw;

  assign sum_raw = acc_q + addend_i;

`ifdef MAC_SATURATE_EN
  logic ovf;
  // Overflow only when both operands share a sign and the sum flips it.
  assign ovf   = (acc_q[XLEN-1] == addend_i[XLEN-1]) && (sum_raw[XLEN-1] != acc_q[XLEN-1]);
  assign sum_o = !ovf           ? sum_raw :
                 acc_q[XLEN-1]  ? {1'b1, {(XLEN-1){1'b0}}} :
                                  {1'b0, {(XLEN-1){1'b1}}};
`else
  assign sum_o = sum_raw;
`endif

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (we_i) acc_d = sum_o;
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mac_seq.sv
// mac_seq: multi-cycle multiply-accumulate unit for the Execute stage.
// A mac latches its operands in IDLE, walks ITER unsigned K-bit digits of B
// in RUN, then presents acc + A*B in DONE. clear/read finish in IDLE.
// Build option: MAC_SATURATE_EN (saturating acc update, see mac_acc).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   mac_validE          MAC instruction present in Execute
//   Funct3E             000 mac, 001 clear, 010 read (others read)
//   SrcAE, SrcBE        signed operands
//   StallE, FlushE      hazard-unit controls
//   MACStallE           structural stall request
//   MACDoneE            MACResultE valid this cycle
//   MACResultE          result to writeback
module mac_seq import cvw::*; #(
  parameter int XLEN = 64,
  parameter int ITER = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mac_validE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            StallE,
  input  logic            FlushE,
  output logic            MACStallE,
  output logic            MACDoneE,
  output logic [XLEN-1:0] MACResultE
);

  localparam int K  = XLEN / ITER;
  localparam int KW = $clog2(K);
  localparam int CW = $clog2(ITER);
  localparam int SW = CW + KW;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  mac_state_t      state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, part_q, part_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [SW-1:0]   shamt;
  logic [K-1:0]    digit;
  logic [XLEN-1:0] term, acc, acc_sum;
  logic            acc_clr, acc_we;

  // K is a power of two, so K*cnt is just cnt with KW zero bits appended.
  assign shamt = {cnt_q, {KW{1'b0}}};
  assign digit = K'(b_q >> shamt);
  // Digits are taken unsigned; B's sign correction is -A*2^XLEN, which is
  // zero modulo 2^XLEN, so the truncated sum already equals low(A*B).
  assign term  = (a_q * XLEN'(digit)) << shamt;

  // acc is committed only when DONE retires, so a flush in RUN or DONE
  // leaves it untouched; DONE shows the would-be value combinationally.
  mac_acc #(.XLEN(XLEN)) u_acc (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (acc_clr),
    .we_i     (acc_we),
    .addend_i (part_q),
    .acc_o    (acc),
    .sum_o    (acc_sum)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    part_d     = part_q;
    cnt_d      = cnt_q;
    MACStallE  = 1'b0;
    MACDoneE   = 1'b0;
    MACResultE = '0;
    acc_clr    = 1'b0;
    acc_we     = 1'b0;
    if (reset) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (mac_validE && !FlushE) begin
          if (Funct3E == MAC_OP_MAC) begin
            state_d   = RUN;
            a_d       = SrcAE;
            b_d       = SrcBE;
            part_d    = '0;
            cnt_d     = '0;
            MACStallE = 1'b1;
          end else begin
            MACDoneE = 1'b1;
            if (Funct3E == MAC_OP_CLR) acc_clr = 1'b1;
            else                       MACResultE = acc;
          end
        end
        RUN: begin
          MACStallE = 1'b1;
          part_d    = part_q + term;
          cnt_d     = cnt_q + 1'b1;
          if (FlushE)             state_d = IDLE;
          else if (cnt_q == LAST) state_d = DONE;
        end
        DONE: begin
          if (FlushE) begin
            state_d = IDLE;
          end else begin
            MACDoneE   = 1'b1;
            MACResultE = acc_sum;
            if (!StallE) begin
              acc_we  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
